// File: rtl/dpram_fifo_ctrl_pkg.sv
// Shared defaults and types for the dpram FIFO controller, its wrapper and bench.
package dpram_fifo_ctrl_pkg;

    localparam int DEF_ADDR_WIDTH = 4;
    localparam int DEF_DATA_WIDTH = 4;

    // Per-cycle transfer events decoded by the controller.
    typedef struct packed {
        logic push;
        logic pop;
        logic issue;
    } fifo_evt_t;

endpackage

// File: rtl/dpram_fifo_ctrl_if.sv
// Producer, consumer, RAM-port and status signals of the dpram FIFO controller.
interface dpram_fifo_ctrl_if
    import dpram_fifo_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) ();

    // Both sides use valid/ready: a word moves on a clock edge where valid and ready are both 1;
    // valid never depends on ready, and in_ready is decoded from registers only.
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  ram_wren;
    logic [ADDR_WIDTH-1:0] ram_wraddr;
    logic [DATA_WIDTH-1:0] ram_wrdata;
    logic [ADDR_WIDTH-1:0] ram_rdaddr;
    logic [DATA_WIDTH-1:0] ram_rddata;
    logic [ADDR_WIDTH+1:0] count;
    logic                  full;
    logic                  empty;

    modport slave (
        input  in_valid, in_data, out_ready, ram_rddata,
        output in_ready, out_valid, out_data, ram_wren, ram_wraddr, ram_wrdata,
               ram_rdaddr, count, full, empty
    );

    modport master (
        output in_valid, in_data, out_ready, ram_rddata,
        input  in_ready, out_valid, out_data, ram_wren, ram_wraddr, ram_wrdata,
               ram_rdaddr, count, full, empty
    );

endinterface

// File: rtl/dpram_fifo_ctrl_obuf.sv
// Two-entry show-ahead head buffer: pop shifts first, then a load fills the first free slot.
module dpram_fifo_obuf #(
    parameter int DATA_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  load_i,
    input  logic [DATA_WIDTH-1:0] load_data_i,
    input  logic                  pop_i,
    output logic [1:0]            ob_cnt_o,
    output logic [DATA_WIDTH-1:0] head_o
);

    logic [1:0][DATA_WIDTH-1:0] ob_q, ob_d;
    logic [1:0]                 cnt_q, cnt_d, cnt_shift;

    always_comb begin
        ob_d      = ob_q;
        cnt_shift = cnt_q;
        if (pop_i) begin
            ob_d[0]   = ob_q[1];
            cnt_shift = cnt_q - 2'd1;
        end
        if (load_i) begin
            if (cnt_shift == 2'd0) begin
                ob_d[0] = load_data_i;
            end else begin
                ob_d[1] = load_data_i;
            end
        end
        cnt_d = cnt_shift + {1'b0, load_i};
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ob_q  <= '0;
            cnt_q <= 2'd0;
        end else begin
            ob_q  <= ob_d;
            cnt_q <= cnt_d;
        end
    end

    assign ob_cnt_o = cnt_q;
    assign head_o   = ob_q[0];

endmodule

// File: rtl/dpram_fifo_ctrl.sv
// Show-ahead FIFO controller around a registered-read dual-port RAM, 1 push + 1 pop per cycle.
module dpram_fifo_ctrl
    import dpram_fifo_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input logic             clk,
    input logic             rstn,
    dpram_fifo_ctrl_if.slave bus
);

    localparam int RAM_SIZE   = 2 ** ADDR_WIDTH;
    localparam int OBUF_DEPTH = 2;

    logic [ADDR_WIDTH-1:0] wrptr_q, wrptr_d;
    logic [ADDR_WIDTH-1:0] rdptr_q, rdptr_d;
    logic [ADDR_WIDTH:0]   mem_cnt_q, mem_cnt_d;
    logic                  rd_pending_q, rd_pending_d;
    logic [1:0]            ob_cnt;
    logic [DATA_WIDTH-1:0] ob_head;
    logic                  full;
    logic [2:0]            ob_occ, ob_room;
    fifo_evt_t             evt;

    // A read is issued only if its data is guaranteed a free head slot on arrival.
    always_comb begin
        evt          = '0;
        full         = (mem_cnt_q == (ADDR_WIDTH+1)'(RAM_SIZE));
        evt.push     = bus.in_valid & ~full;
        evt.pop      = (ob_cnt != 2'd0) & bus.out_ready;
        ob_occ       = {1'b0, ob_cnt} + {2'b0, rd_pending_q};
        ob_room      = 3'(OBUF_DEPTH) + {2'b0, evt.pop};
        evt.issue    = (mem_cnt_q != '0) && (ob_occ < ob_room);
        wrptr_d      = wrptr_q + ADDR_WIDTH'(evt.push);
        rdptr_d      = rdptr_q + ADDR_WIDTH'(evt.issue);
        mem_cnt_d    = mem_cnt_q + (ADDR_WIDTH+1)'(evt.push) - (ADDR_WIDTH+1)'(evt.issue);
        rd_pending_d = evt.issue;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wrptr_q      <= '0;
            rdptr_q      <= '0;
            mem_cnt_q    <= '0;
            rd_pending_q <= 1'b0;
        end else begin
            wrptr_q      <= wrptr_d;
            rdptr_q      <= rdptr_d;
            mem_cnt_q    <= mem_cnt_d;
            rd_pending_q <= rd_pending_d;
        end
    end

    dpram_fifo_obuf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_obuf (
        .clk         (clk),
        .rstn        (rstn),
        .load_i      (rd_pending_q),
        .load_data_i (bus.ram_rddata),
        .pop_i       (evt.pop),
        .ob_cnt_o    (ob_cnt),
        .head_o      (ob_head)
    );

    assign bus.in_ready   = ~full;
    assign bus.ram_wren   = evt.push;
    assign bus.ram_wraddr = wrptr_q;
    assign bus.ram_wrdata = bus.in_data;
    assign bus.ram_rdaddr = rdptr_q;
    assign bus.out_valid  = (ob_cnt != 2'd0);
    assign bus.out_data   = ob_head;
    assign bus.count      = (ADDR_WIDTH+2)'(mem_cnt_q) + (ADDR_WIDTH+2)'(rd_pending_q)
                          + (ADDR_WIDTH+2)'(ob_cnt);
    assign bus.full       = full;
    assign bus.empty      = (bus.count == '0);

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Bench for dpram_fifo_ctrl with a behavioural registered-read RAM and a queue reference model.
module tb_dpram_fifo_ctrl;
    import dpram_fifo_ctrl_pkg::*;

    localparam int AW = DEF_ADDR_WIDTH;
    localparam int DW = DEF_DATA_WIDTH;

    logic clk;
    logic rstn;

    dpram_fifo_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    dpram_fifo_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    // ---------------- RAM model (write port + registered read) ----------------
    logic [DW-1:0] ram_mem [2**AW];

    initial begin
        for (int i = 0; i < 2**AW; i++) ram_mem[i] = DW'($urandom);
        bus.ram_rddata = '0;
    end

    always @(posedge clk) begin
        if (bus.ram_wren) ram_mem[bus.ram_wraddr] <= bus.ram_wrdata;
        bus.ram_rddata <= ram_mem[bus.ram_rdaddr];
    end

    // ---------------- scoreboard ----------------
    int            n_checks = 0;
    int            n_errors = 0;
    int            n_push   = 0;
    int            n_pop    = 0;
    logic [DW-1:0] exp_q[$];
    logic [AW-1:0] wr_idx;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        rstn          = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        exp_q.delete();
        wr_idx = '0;
    endtask

    // One clock cycle with inputs already driven: compare against the queue model, then advance.
    task automatic step();
        logic [DW-1:0] head;
        #1;
        chk("count", 32'(bus.count), 32'(exp_q.size()));
        chk("empty", 32'(bus.empty), 32'(exp_q.size() == 0));
        if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                chk("pop_on_empty", 32'(bus.out_valid), 32'd0);
            end else begin
                head = exp_q.pop_front();
                chk("order", 32'(bus.out_data), 32'(head));
            end
            n_pop++;
        end
        if (bus.in_valid && bus.in_ready) begin
            chk("wraddr", 32'(bus.ram_wraddr), 32'(wr_idx));
            chk("wren", 32'(bus.ram_wren), 32'd1);
            exp_q.push_back(bus.in_data);
            wr_idx = wr_idx + 1'b1;
            n_push++;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // ---------------- table-driven vectors ----------------
    typedef struct {
        logic          iv;
        logic [DW-1:0] d;
        logic          ordy;
        logic          ev;
        logic [DW-1:0] ed;
        logic [AW+1:0] ec;
    } vec_t;

    vec_t vt[18];

    function automatic vec_t mk(logic iv, logic [DW-1:0] d, logic ordy,
                                logic ev, logic [DW-1:0] ed, logic [AW+1:0] ec);
        vec_t v;
        v.iv = iv; v.d = d; v.ordy = ordy; v.ev = ev; v.ed = ed; v.ec = ec;
        return v;
    endfunction

    initial begin
        int            budget;
        logic [DW-1:0] w;
        int            pops_before;

        // single word with stall, then pop
        vt[0]  = mk(1, 4'hA, 0, 0, 4'h0, 0);
        vt[1]  = mk(0, 4'h0, 0, 0, 4'h0, 1);
        vt[2]  = mk(0, 4'h0, 0, 0, 4'h0, 1);
        vt[3]  = mk(0, 4'h0, 1, 1, 4'hA, 1);
        vt[4]  = mk(0, 4'h0, 0, 0, 4'h0, 0);
        // push with out_ready on empty: no bypass
        vt[5]  = mk(1, 4'h5, 1, 0, 4'h0, 0);
        vt[6]  = mk(0, 4'h0, 1, 0, 4'h0, 1);
        vt[7]  = mk(0, 4'h0, 1, 0, 4'h0, 1);
        vt[8]  = mk(0, 4'h0, 1, 1, 4'h5, 1);
        vt[9]  = mk(0, 4'h0, 0, 0, 4'h0, 0);
        // two back-to-back words, stalled head stays stable
        vt[10] = mk(1, 4'h3, 0, 0, 4'h0, 0);
        vt[11] = mk(1, 4'hC, 0, 0, 4'h0, 1);
        vt[12] = mk(0, 4'h0, 0, 0, 4'h0, 2);
        vt[13] = mk(0, 4'h0, 0, 1, 4'h3, 2);
        vt[14] = mk(0, 4'h0, 0, 1, 4'h3, 2);
        vt[15] = mk(0, 4'h0, 1, 1, 4'h3, 2);
        vt[16] = mk(0, 4'h0, 1, 1, 4'hC, 1);
        vt[17] = mk(0, 4'h0, 0, 0, 4'h0, 0);

        // ---- reset idle ----
        rstn          = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        wr_idx        = '0;
        #1;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_data", 32'(bus.out_data), 32'd0);
        chk("rst_empty", 32'(bus.empty), 32'd1);
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_full", 32'(bus.full), 32'd0);
        bus.in_valid = 1'b1;
        #1;
        chk("rst_wren_follows", 32'(bus.ram_wren), 32'd1);
        @(negedge clk);
        do_reset();

        // ---- table ----
        for (int i = 0; i < 18; i++) begin
            bus.in_valid  = vt[i].iv;
            bus.in_data   = vt[i].d;
            bus.out_ready = vt[i].ordy;
            #1;
            chk($sformatf("vec%0d_out_valid", i), 32'(bus.out_valid), 32'(vt[i].ev));
            if (vt[i].ev) chk($sformatf("vec%0d_out_data", i), 32'(bus.out_data), 32'(vt[i].ed));
            chk($sformatf("vec%0d_count", i), 32'(bus.count), 32'(vt[i].ec));
            chk($sformatf("vec%0d_empty", i), 32'(bus.empty), 32'(vt[i].ec == 0));
            chk($sformatf("vec%0d_in_ready", i), 32'(bus.in_ready), 32'd1);
            chk($sformatf("vec%0d_wren", i), 32'(bus.ram_wren), 32'(vt[i].iv));
            @(posedge clk);
            @(negedge clk);
        end

        // ---- fill to capacity ----
        do_reset();
        for (int i = 0; i < 18; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = (i < 16) ? DW'(i) : DW'(i - 15);
            #1 chk("fill_in_ready", 32'(bus.in_ready), 32'd1);
            step();
        end
        bus.in_valid = 1'b0;
        step();
        step();
        chk("full_count", 32'(bus.count), 32'd18);
        chk("full_flag", 32'(bus.full), 32'd1);
        chk("full_in_ready", 32'(bus.in_ready), 32'd0);
        bus.in_valid = 1'b1;
        bus.in_data  = 4'h7;
        #1 chk("full_no_wren", 32'(bus.ram_wren), 32'd0);
        step();

        // ---- drain order, one word per cycle ----
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 18; i++) begin
            #1;
            chk("drain_valid", 32'(bus.out_valid), 32'd1);
            if (i == 0) chk("drain_in_ready_still_low", 32'(bus.in_ready), 32'd0);
            if (i == 1) chk("drain_in_ready_back", 32'(bus.in_ready), 32'd1);
            step();
        end
        #1;
        chk("drain_empty", 32'(bus.empty), 32'd1);
        chk("drain_out_valid", 32'(bus.out_valid), 32'd0);
        @(negedge clk);

        // ---- random streaming with wrap-around ----
        do_reset();
        n_push = 0;
        budget = 0;
        while (n_push < 40 && budget < 400) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.in_data   = DW'($urandom);
            bus.out_ready = ($urandom_range(0, 1) != 0);
            step();
            budget++;
        end
        if (n_push < 40) chk("stream_push_timeout", 32'(n_push), 32'd40);

        // continuous push + pop: 1 word per cycle once the pipe is primed
        for (int c = 0; c < 24; c++) begin
            bus.in_valid  = 1'b1;
            bus.in_data   = DW'($urandom);
            bus.out_ready = 1'b1;
            #1 if (c >= 3) chk("throughput_valid", 32'(bus.out_valid), 32'd1);
            step();
        end
        bus.in_valid = 1'b0;
        budget = 0;
        while ((exp_q.size() != 0) && budget < 40) begin
            step();
            budget++;
        end
        chk("stream_drained", 32'(exp_q.size()), 32'd0);
        #1 chk("stream_empty", 32'(bus.empty), 32'd1);
        @(negedge clk);

        // ---- reset mid-stream ----
        do_reset();
        for (int i = 0; i < 7; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = DW'($urandom);
            step();
        end
        bus.in_valid = 1'b0;
        step();
        chk("mid_count7", 32'(bus.count), 32'd7);
        rstn = 1'b0;
        #1;
        chk("mid_rst_count", 32'(bus.count), 32'd0);
        chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_wraddr", 32'(bus.ram_wraddr), 32'd0);
        chk("mid_rst_rdaddr", 32'(bus.ram_rdaddr), 32'd0);
        chk("mid_rst_empty", 32'(bus.empty), 32'd1);
        @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        exp_q.delete();
        wr_idx = '0;
        w = ~ram_mem[0];
        bus.in_valid = 1'b1;
        bus.in_data  = w;
        step();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        pops_before   = n_pop;
        budget        = 0;
        while (n_pop == pops_before && budget < 6) begin
            step();
            budget++;
        end
        chk("mid_new_word_popped", 32'(n_pop - pops_before), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
